reg_issue_scoreboard: RTL
=========================

Name: reg_issue_scoreboard

Overview:
- Dual-issue register scoreboard and issue arbiter placed in front of the 128 x 128-bit register file.
- Tracks an outstanding-write countdown per register and decides each cycle whether the even-pipe and odd-pipe instructions may issue.
- Blocks RAW, WAW and intra-pair hazards, so register-file reads at issue always return committed data.
- Keeps a saturating stall-cycle counter for performance monitoring.

Parameters:
- REG_COUNT, 128, number of architectural registers.
- REG_ADDR_WIDTH, 7, register address width (log2 REG_COUNT).
- LAT_WIDTH, 3, width of latency field and per-register countdown; maximum latency is 2^LAT_WIDTH-1.
- STALL_CNT_WIDTH, 32, width of the stall-cycle counter.

Ports:
- clk  in  1  clock; all state on rising edge.
- reset  in  1  asynchronous, active-low reset.
- flush  in  1  synchronous clear of all pending-write state.
- req_valid_even / req_valid_odd  in  1  instruction present in the slot.
- ra_even, rb_even, rc_even, ra_odd, rb_odd, rc_odd  in  REG_ADDR_WIDTH  source register addresses.
- src_use_even, src_use_odd  in  3  per-source use mask; bit0=ra, bit1=rb, bit2=rc.
- rt_even, rt_odd  in  REG_ADDR_WIDTH  destination register address.
- rt_wr_even, rt_wr_odd  in  1  instruction writes rt.
- lat_even, lat_odd  in  LAT_WIDTH  cycles from issue until rt is committed in the register file.
- grant_even, grant_odd  out  1  slot issues this cycle (combinational).
- reg_busy  out  REG_COUNT  bit i set when register i has a nonzero countdown.
- stall_cnt  out  STALL_CNT_WIDTH  saturating count of stall cycles.

Behaviour:
- State: cnt[i] (LAT_WIDTH bits) per register; stall_cnt.
- Reset (reset low, asynchronous): all cnt=0 and stall_cnt=0, so reg_busy=0. grant outputs follow the combinational rules with all registers free.
- Program order: the even slot is older than the odd slot.
- hazard_X is true when either condition holds:
  - Any used source of slot X has cnt != 0.
  - rt_wr_X=1 and cnt[rt_X] != 0 (WAW).
- grant_even = req_valid_even & ~hazard_even & ~flush.
- grant_odd = req_valid_odd & ~hazard_odd & ~flush & (grant_even | ~req_valid_even) & ~pair_dep.
  - In-order rule: odd never issues ahead of a valid, stalled even.
- pair_dep is true when req_valid_even & rt_wr_even and either:
  - a used odd source equals rt_even, or
  - rt_wr_odd and rt_odd equals rt_even.
- Countdown update each cycle, per register:
  - cnt != 0 decrements by 1.
  - A granted writer with rt_wr=1 loads cnt[rt] = max(lat,1). The load overrides the decrement.
  - lat=0 is treated as 1.
- Timing: a writer granted in cycle t with lat L leaves rt busy for cycles t+1..t+L. A dependent source may issue in cycle t+L+1 at the earliest, when cnt reaches 0 at the edge ending cycle t+L.
- Simultaneous loads of the same rt from both slots cannot occur; pair_dep blocks the odd slot.
- flush=1: all cnt cleared at the next edge, both grants 0 this cycle, and stall_cnt does not increment.
- Requesters hold valid and fields stable until granted; the block stores no request state.
- stall_cnt increments by 1 in any cycle, flush excepted, where either condition holds:
  - req_valid_even & ~grant_even, or
  - req_valid_odd & ~grant_odd.
  - It saturates at all-ones.
- Register 0 has no special casing; it is scoreboarded like the others.

Test Plan:
- Reset released, even valid: ra=1, rb=2, rt=3, wr, lat=4. Expect grant_even=1 the same cycle, then reg_busy[3]=1 for exactly 4 cycles, then 0.
- RAW: after the above, even reads ra=3 every cycle from t+1. Expect grant_even=0 for cycles t+1..t+4, grant_even=1 at t+5, and stall_cnt=4.
- Intra-pair: even writes rt=5, odd reads ra=5, both free. Expect grant_even=1, grant_odd=0. Next cycle odd is still blocked by busy[5].
- In-order: even stalled on busy reg 9, odd independent (rt=10). Expect grant_odd=0 until even is granted, then both grants may assert together.
- WAW plus lat=0: even rt=7, lat=0 issues, and busy[7] is set for exactly 1 cycle. Odd writing rt=7 the next cycle is stalled 1 cycle.
- Flush and async reset: with busy regs 3 and 4, flush=1 gives grants 0 and reg_busy=0 the next cycle. Asserting reset mid-countdown clears reg_busy and stall_cnt immediately, without waiting for clk.

Source files
------------

// File: rtl/reg_issue_scoreboard.sv
`default_nettype none
// ============================================================================
// Module      : reg_issue_scoreboard
// Description : Dual-issue register scoreboard and issue arbiter with per-register
//               write countdowns, RAW/WAW/intra-pair hazard blocking and a
//               saturating stall-cycle counter.
// Revision    : 1.0 - initial release
// ============================================================================
module reg_issue_scoreboard #(
  parameter int REG_COUNT       = 128,
  parameter int REG_ADDR_WIDTH  = 7,
  parameter int LAT_WIDTH       = 3,
  parameter int STALL_CNT_WIDTH = 32
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       flush,
  input  logic                       req_valid_even,
  input  logic                       req_valid_odd,
  input  logic [REG_ADDR_WIDTH-1:0]  ra_even,
  input  logic [REG_ADDR_WIDTH-1:0]  rb_even,
  input  logic [REG_ADDR_WIDTH-1:0]  rc_even,
  input  logic [REG_ADDR_WIDTH-1:0]  ra_odd,
  input  logic [REG_ADDR_WIDTH-1:0]  rb_odd,
  input  logic [REG_ADDR_WIDTH-1:0]  rc_odd,
  input  logic [2:0]                 src_use_even,
  input  logic [2:0]                 src_use_odd,
  input  logic [REG_ADDR_WIDTH-1:0]  rt_even,
  input  logic [REG_ADDR_WIDTH-1:0]  rt_odd,
  input  logic                       rt_wr_even,
  input  logic                       rt_wr_odd,
  input  logic [LAT_WIDTH-1:0]       lat_even,
  input  logic [LAT_WIDTH-1:0]       lat_odd,
  output logic                       grant_even,
  output logic                       grant_odd,
  output logic [REG_COUNT-1:0]       reg_busy,
  output logic [STALL_CNT_WIDTH-1:0] stall_cnt
);

  localparam logic [LAT_WIDTH-1:0] c_LAT_MIN = LAT_WIDTH'(1);

  logic [REG_COUNT-1:0]       w_busy;
  logic                       w_haz_even;
  logic                       w_haz_odd;
  logic                       w_pair_dep;
  logic                       w_grant_even;
  logic                       w_grant_odd;
  logic                       w_load_even;
  logic                       w_load_odd;
  logic [LAT_WIDTH-1:0]       w_lat_even;
  logic [LAT_WIDTH-1:0]       w_lat_odd;
  logic                       w_stall;
  logic [STALL_CNT_WIDTH-1:0] r_stall_cnt;

  assign w_haz_even = (src_use_even[0] & w_busy[ra_even])
                    | (src_use_even[1] & w_busy[rb_even])
                    | (src_use_even[2] & w_busy[rc_even])
                    | (rt_wr_even      & w_busy[rt_even]);

  assign w_haz_odd  = (src_use_odd[0] & w_busy[ra_odd])
                    | (src_use_odd[1] & w_busy[rb_odd])
                    | (src_use_odd[2] & w_busy[rc_odd])
                    | (rt_wr_odd      & w_busy[rt_odd]);

  // Odd is younger: it must not read or overwrite what the even slot writes.
  assign w_pair_dep = req_valid_even & rt_wr_even &
                      ((src_use_odd[0] & (ra_odd == rt_even))
                     | (src_use_odd[1] & (rb_odd == rt_even))
                     | (src_use_odd[2] & (rc_odd == rt_even))
                     | (rt_wr_odd      & (rt_odd == rt_even)));

  assign w_grant_even = req_valid_even & ~w_haz_even & ~flush;
  assign w_grant_odd  = req_valid_odd & ~w_haz_odd & ~flush
                      & (w_grant_even | ~req_valid_even) & ~w_pair_dep;

  assign w_load_even = w_grant_even & rt_wr_even;
  assign w_load_odd  = w_grant_odd & rt_wr_odd;
  assign w_lat_even  = (lat_even == '0) ? c_LAT_MIN : lat_even;
  assign w_lat_odd   = (lat_odd == '0) ? c_LAT_MIN : lat_odd;

  generate
    for (genvar gi = 0; gi < REG_COUNT; gi++) begin : g_reg
      logic [LAT_WIDTH-1:0] r_cnt;

      always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
          r_cnt <= '0;
        end else if (flush) begin
          r_cnt <= '0;
        end else if (w_load_even && (rt_even == REG_ADDR_WIDTH'(gi))) begin
          r_cnt <= w_lat_even;
        end else if (w_load_odd && (rt_odd == REG_ADDR_WIDTH'(gi))) begin
          r_cnt <= w_lat_odd;
        end else if (r_cnt != '0) begin
          r_cnt <= r_cnt - LAT_WIDTH'(1);
        end
      end

      assign w_busy[gi] = (r_cnt != '0);
    end
  endgenerate

  assign w_stall = ~flush & ((req_valid_even & ~w_grant_even)
                           | (req_valid_odd  & ~w_grant_odd));

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_stall_cnt <= '0;
    end else if (w_stall && (r_stall_cnt != '1)) begin
      r_stall_cnt <= r_stall_cnt + STALL_CNT_WIDTH'(1);
    end
  end

  assign grant_even = w_grant_even;
  assign grant_odd  = w_grant_odd;
  assign reg_busy   = w_busy;
  assign stall_cnt  = r_stall_cnt;

endmodule
`default_nettype wire
